// File: rtl/eth_rx.sv
// RMII receive path: preamble/SFD hunt, LSB-first byte assembly, destination filter,
// CRC-32 residue check and payload streaming through a 5-byte hold-back that strips the FCS.
module eth_rx #(
  parameter int unsigned pMII_WIDTH = 2,
  parameter logic [47:0] pMAC_ADDR  = 48'h020000000001,
  parameter int unsigned pMIN_BYTES = 64,
  parameter int unsigned pMAX_BYTES = 1518
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Crs_Dv,
  input  logic [pMII_WIDTH-1:0] Rx_Data,
  output logic                  Dat_Vld,
  output logic [7:0]            Data,
  output logic                  Data_Last,
  output logic                  Frame_Err,
  output logic                  Hdr_Vld,
  output logic [47:0]           Src_Addr,
  output logic [15:0]           Len_Type
);

  localparam int unsigned CNT_W    = 11;
  localparam int unsigned HB_DEPTH = 5;
  localparam int unsigned HB_CW    = 3;
  localparam int unsigned PRE_W    = 3;

  localparam logic [CNT_W-1:0] MIN_BYTES = CNT_W'(pMIN_BYTES);
  localparam logic [CNT_W-1:0] MAX_BYTES = CNT_W'(pMAX_BYTES);
  localparam logic [HB_CW-1:0] HB_FULL   = HB_CW'(HB_DEPTH);
  localparam logic [PRE_W-1:0] PRE_MIN   = PRE_W'(4);
  localparam logic [31:0]      CRC_POLY  = 32'hEDB88320;
  localparam logic [31:0]      CRC_GOOD  = 32'hDEBB20E3;
  localparam logic [47:0]      BCAST     = 48'hFFFFFFFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_PAYLOAD,
    S_END,
    S_DROP
  } state_t;

  // Reflected CRC-32, two bits per clock, bit 0 first in time.
  function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  logic                  crs_q;
  logic [pMII_WIDTH-1:0] rxd_q;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] dibit_cnt_q, dibit_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]      crc_q, crc_d;
  logic [5:0]       sr_q, sr_d;
  logic [47:0]      hsh_q, hsh_d;
  logic [7:0]       len_sh_q, len_sh_d;
  logic [7:0]       hb_q [HB_DEPTH];
  logic [7:0]       hb_d [HB_DEPTH];
  logic [HB_CW-1:0] hb_cnt_q, hb_cnt_d;

  logic        dat_vld_q, dat_vld_d;
  logic [7:0]  data_q, data_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic        hdr_vld_q, hdr_vld_d;
  logic [47:0] src_q, src_d;
  logic [15:0] len_q, len_d;

  logic [7:0]       byte_new;
  logic             byte_done;
  logic [CNT_W-3:0] dib_upper;
  logic [CNT_W-1:0] dibit_inc;
  logic [CNT_W-1:0] byte_inc;
  logic [47:0]      dst_word;
  logic             dst_miss;
  logic             hb_full;
  logic             end_err;

  assign byte_new  = {rxd_q, sr_q};
  assign byte_done = (dibit_cnt_q[1:0] == 2'd3);
  assign dib_upper = dibit_cnt_q[CNT_W-1:2];
  // Upper bits saturate while the in-byte phase keeps cycling, so long frames still assemble bytes.
  assign dibit_inc = {(byte_done && !(&dib_upper)) ? dib_upper + (CNT_W-2)'(1) : dib_upper,
                      dibit_cnt_q[1:0] + 2'd1};
  assign byte_inc  = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);
  assign dst_word  = {hsh_q[39:0], byte_new};
  assign dst_miss  = (dst_word != pMAC_ADDR) && (dst_word != BCAST);
  assign hb_full   = (hb_cnt_q == HB_FULL);
  assign end_err   = (crc_q != CRC_GOOD) || (byte_cnt_q < MIN_BYTES) || (dibit_cnt_q[1:0] != 2'd0);

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    dibit_cnt_d = dibit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    sr_d        = sr_q;
    hsh_d       = hsh_q;
    len_sh_d    = len_sh_q;
    hb_d        = hb_q;
    hb_cnt_d    = hb_cnt_q;
    dat_vld_d   = 1'b0;
    data_d      = '0;
    last_d      = 1'b0;
    err_d       = 1'b0;
    hdr_vld_d   = 1'b0;
    src_d       = src_q;
    len_d       = len_q;

    case (state_q)
      S_IDLE: begin
        if (crs_q) begin
          state_d   = S_PREAMBLE;
          pre_cnt_d = '0;
        end
      end

      S_PREAMBLE: begin
        if (!crs_q) begin
          state_d = S_IDLE;
        end else if (rxd_q == 2'b01) begin
          if (pre_cnt_q != PRE_MIN) pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end else if (rxd_q == 2'b11 && pre_cnt_q == PRE_MIN) begin
          state_d     = S_HEADER;
          dibit_cnt_d = '0;
          byte_cnt_d  = '0;
          crc_d       = '1;
          hb_cnt_d    = '0;
        end else begin
          state_d = S_DROP;
        end
      end

      S_HEADER, S_PAYLOAD: begin
        if (!crs_q) begin
          // Whatever is still held back is the FCS; only the oldest byte is released.
          dat_vld_d = 1'b1;
          last_d    = 1'b1;
          data_d    = hb_full ? hb_q[0] : '0;
          err_d     = end_err;
          state_d   = S_END;
        end else begin
          sr_d        = {rxd_q, sr_q[5:2]};
          crc_d       = crc_dibit(crc_q, rxd_q);
          dibit_cnt_d = dibit_inc;
          if (byte_done) begin
            byte_cnt_d = byte_inc;
            if (state_q == S_HEADER) begin
              if (byte_cnt_q < CNT_W'(12)) begin
                hsh_d = {hsh_q[39:0], byte_new};
                if (byte_cnt_q == CNT_W'(5) && dst_miss) state_d = S_DROP;
              end else if (byte_cnt_q == CNT_W'(12)) begin
                len_sh_d = byte_new;
              end else begin
                hdr_vld_d = 1'b1;
                src_d     = hsh_q;
                len_d     = {len_sh_q, byte_new};
                state_d   = S_PAYLOAD;
              end
            end else if (byte_cnt_q >= MAX_BYTES) begin
              dat_vld_d = 1'b1;
              last_d    = 1'b1;
              err_d     = 1'b1;
              data_d    = hb_full ? hb_q[0] : '0;
              state_d   = S_DROP;
            end else if (hb_full) begin
              dat_vld_d = 1'b1;
              data_d    = hb_q[0];
              for (int i = 0; i < int'(HB_DEPTH) - 1; i++) hb_d[i] = hb_q[i+1];
              hb_d[HB_DEPTH-1] = byte_new;
            end else begin
              for (int i = 0; i < int'(HB_DEPTH); i++) begin
                if (HB_CW'(i) == hb_cnt_q) hb_d[i] = byte_new;
              end
              hb_cnt_d = hb_cnt_q + HB_CW'(1);
            end
          end
        end
      end

      S_END: state_d = S_IDLE;

      S_DROP: begin
        if (!crs_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      crs_q       <= 1'b0;
      rxd_q       <= '0;
      state_q     <= S_IDLE;
      pre_cnt_q   <= '0;
      dibit_cnt_q <= '0;
      byte_cnt_q  <= '0;
      crc_q       <= '1;
      sr_q        <= '0;
      hsh_q       <= '0;
      len_sh_q    <= '0;
      hb_q        <= '{default: '0};
      hb_cnt_q    <= '0;
      dat_vld_q   <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      hdr_vld_q   <= 1'b0;
      src_q       <= '0;
      len_q       <= '0;
    end else begin
      crs_q       <= Crs_Dv;
      rxd_q       <= Rx_Data;
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      dibit_cnt_q <= dibit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      sr_q        <= sr_d;
      hsh_q       <= hsh_d;
      len_sh_q    <= len_sh_d;
      hb_q        <= hb_d;
      hb_cnt_q    <= hb_cnt_d;
      dat_vld_q   <= dat_vld_d;
      data_q      <= data_d;
      last_q      <= last_d;
      err_q       <= err_d;
      hdr_vld_q   <= hdr_vld_d;
      src_q       <= src_d;
      len_q       <= len_d;
    end
  end

  assign Dat_Vld   = dat_vld_q;
  assign Data      = data_q;
  assign Data_Last = last_q;
  assign Frame_Err = err_q;
  assign Hdr_Vld   = hdr_vld_q;
  assign Src_Addr  = src_q;
  assign Len_Type  = len_q;

endmodule

// File: tb/tb_eth_rx.sv
// Scoreboard bench for eth_rx: frames are built and FCS'd here, expected beats/headers
// are queued at stimulus time and a negedge monitor pops and compares them.
module tb_eth_rx;

  localparam logic [47:0] STATION = 48'h020000000001;
  localparam logic [47:0] BCAST   = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] OTHER   = 48'h0A0000000002;
  localparam logic [47:0] SRC_B   = 48'h001122334455;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Crs_Dv;
  logic [1:0]  Rx_Data;
  logic        Dat_Vld;
  logic [7:0]  Data;
  logic        Data_Last;
  logic        Frame_Err;
  logic        Hdr_Vld;
  logic [47:0] Src_Addr;
  logic [15:0] Len_Type;

  int checks   = 0;
  int failures = 0;
  int beat_idx = 0;

  logic [9:0]  beat_q [$];
  logic [63:0] hdr_q  [$];
  logic [7:0]  pl     [$];
  logic [7:0]  frm    [$];
  logic [1:0]  dib    [$];
  logic [9:0]  exp_b;
  logic [63:0] exp_h;

  eth_rx dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Crs_Dv    (Crs_Dv),
    .Rx_Data   (Rx_Data),
    .Dat_Vld   (Dat_Vld),
    .Data      (Data),
    .Data_Last (Data_Last),
    .Frame_Err (Frame_Err),
    .Hdr_Vld   (Hdr_Vld),
    .Src_Addr  (Src_Addr),
    .Len_Type  (Len_Type)
  );

  always #10 Clk = ~Clk;

  // Monitor: every strobe the DUT presents must match the head of its queue.
  always @(negedge Clk) begin
    if (Dat_Vld && Hdr_Vld) begin
      checks++;
      failures++;
      $display("FAIL strobe_overlap got dat_vld=1 hdr_vld=1 required never both");
    end
    if (Dat_Vld) begin
      checks++;
      if (beat_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected got data=%h last=%b err=%b required no beat", Data, Data_Last, Frame_Err);
      end else begin
        exp_b = beat_q.pop_front();
        if ({Data, Data_Last, Frame_Err} !== exp_b)
          begin
            failures++;
            $display("FAIL beat%0d got data=%h last=%b err=%b required data=%h last=%b err=%b",
                     beat_idx, Data, Data_Last, Frame_Err, exp_b[9:2], exp_b[1], exp_b[0]);
          end
      end
      beat_idx++;
    end
    if (Hdr_Vld) begin
      checks++;
      if (hdr_q.size() == 0) begin
        failures++;
        $display("FAIL hdr_unexpected got src=%h type=%h required no header", Src_Addr, Len_Type);
      end else begin
        exp_h = hdr_q.pop_front();
        if ({Src_Addr, Len_Type} !== exp_h) begin
          failures++;
          $display("FAIL hdr got src=%h type=%h required src=%h type=%h",
                   Src_Addr, Len_Type, exp_h[63:16], exp_h[15:0]);
        end
      end
    end
  end

  function automatic void set_pl(input int n, input int start, input int step);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'(start + i * step));
  endfunction

  function automatic logic [31:0] frm_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (frm[j]) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ frm[j][k]) c = (c >> 1) ^ 32'hEDB88320;
        else                  c = c >> 1;
      end
    end
    return ~c;
  endfunction

  function automatic void build_frame(input logic [47:0] dst, input logic [47:0] src,
                                      input logic [15:0] typ, input bit add_fcs);
    logic [31:0] fcs;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
    frm.push_back(typ[15:8]);
    frm.push_back(typ[7:0]);
    foreach (pl[i]) frm.push_back(pl[i]);
    if (add_fcs) begin
      fcs = frm_fcs();
      for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    end
  endfunction

  function automatic void push_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) dib.push_back(b[2*k +: 2]);
  endfunction

  function automatic void frame_dibs(input int extra);
    dib.delete();
    for (int i = 0; i < 7; i++) push_byte(8'h55);
    push_byte(8'hD5);
    foreach (frm[j]) push_byte(frm[j]);
    for (int i = 0; i < extra; i++) dib.push_back(2'b00);
  endfunction

  function automatic void expect_frame(input logic [47:0] src, input logic [15:0] typ,
                                       input int n, input bit err);
    hdr_q.push_back({src, typ});
    for (int i = 0; i < n; i++)
      beat_q.push_back({pl[i], 1'(i == n - 1), 1'((i == n - 1) && err)});
  endfunction

  task automatic send_dibs(input int rst_at);
    for (int i = 0; i < dib.size(); i++) begin
      @(negedge Clk);
      Crs_Dv  = 1'b1;
      Rx_Data = dib[i];
      if (i == rst_at) begin
        Rst_n = 1'b0;
        #1;
        checks++;
        if (Src_Addr !== 48'h0 || Len_Type !== 16'h0) begin
          failures++;
          $display("FAIL rst_mid_hdr got src=%h type=%h required 0", Src_Addr, Len_Type);
        end
        checks++;
        if ({Dat_Vld, Data, Data_Last, Frame_Err, Hdr_Vld} !== 12'h0) begin
          failures++;
          $display("FAIL rst_mid_beat got vld=%b data=%h last=%b err=%b hdr=%b required 0",
                   Dat_Vld, Data, Data_Last, Frame_Err, Hdr_Vld);
        end
      end
      if (i == rst_at + 3) Rst_n = 1'b1;
    end
    repeat (24) begin
      @(negedge Clk);
      Crs_Dv  = 1'b0;
      Rx_Data = 2'b00;
    end
  endtask

  task automatic drain(input string name);
    repeat (40) @(negedge Clk);
    checks++;
    if (beat_q.size() != 0 || hdr_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s got pending_beats=%0d pending_hdrs=%0d required 0",
               name, beat_q.size(), hdr_q.size());
      beat_q.delete();
      hdr_q.delete();
    end
  endtask

  initial begin
    Rst_n   = 1'b0;
    Crs_Dv  = 1'b0;
    Rx_Data = 2'b00;
    repeat (3) @(negedge Clk);
    checks++;
    if ({Dat_Vld, Data, Data_Last, Frame_Err, Hdr_Vld, Src_Addr, Len_Type} !== 76'h0) begin
      failures++;
      $display("FAIL reset_outputs got vld=%b data=%h last=%b err=%b hdr=%b src=%h type=%h required 0",
               Dat_Vld, Data, Data_Last, Frame_Err, Hdr_Vld, Src_Addr, Len_Type);
    end
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);

    // Broadcast, 46-byte ramp payload, good FCS.
    set_pl(46, 0, 1);
    build_frame(BCAST, STATION, 16'h0800, 1'b1);
    expect_frame(STATION, 16'h0800, 46, 1'b0);
    frame_dibs(0);
    send_dibs(-1);
    drain("broadcast");

    // Same frame, one payload bit flipped after the FCS was computed.
    set_pl(46, 0, 1);
    build_frame(BCAST, STATION, 16'h0800, 1'b1);
    frm[24] = frm[24] ^ 8'h04;
    pl[10]  = pl[10] ^ 8'h04;
    expect_frame(STATION, 16'h0800, 46, 1'b1);
    frame_dibs(0);
    send_dibs(-1);
    drain("crc_error");

    // Foreign unicast destination: filtered, nothing emitted.
    set_pl(46, 0, 1);
    build_frame(OTHER, SRC_B, 16'h0800, 1'b1);
    frame_dibs(0);
    send_dibs(-1);
    drain("dest_filter");

    // Station unicast, 72-byte payload as a transmitter would send it.
    set_pl(72, 3, 7);
    build_frame(STATION, SRC_B, 16'h88B5, 1'b1);
    expect_frame(SRC_B, 16'h88B5, 72, 1'b0);
    frame_dibs(0);
    send_dibs(-1);
    drain("unicast72");

    // 40-byte runt with a valid FCS.
    set_pl(22, 8'h40, 1);
    build_frame(BCAST, SRC_B, 16'h0806, 1'b1);
    expect_frame(SRC_B, 16'h0806, 22, 1'b1);
    frame_dibs(0);
    send_dibs(-1);
    drain("runt");

    // Trailing dribble dibit: alignment error on an otherwise good frame.
    set_pl(46, 0, 1);
    build_frame(BCAST, STATION, 16'h0800, 1'b1);
    expect_frame(STATION, 16'h0800, 46, 1'b1);
    frame_dibs(1);
    send_dibs(-1);
    drain("alignment");

    // 1530-byte stream: 1500 beats, the 1500th flagged last+error at byte 1519.
    set_pl(1516, 0, 1);
    build_frame(BCAST, SRC_B, 16'h0800, 1'b0);
    hdr_q.push_back({SRC_B, 16'h0800});
    for (int i = 0; i < 1499; i++) beat_q.push_back({pl[i], 1'b0, 1'b0});
    beat_q.push_back({pl[1499], 1'b1, 1'b1});
    frame_dibs(0);
    send_dibs(-1);
    drain("oversize");

    // Preamble followed by a bad dibit instead of the SFD.
    dib.delete();
    for (int i = 0; i < 16; i++) dib.push_back(2'b01);
    dib.push_back(2'b10);
    for (int i = 0; i < 20; i++) dib.push_back(2'b00);
    send_dibs(-1);
    drain("bad_sfd");

    // Reset asserted in payload byte 3: header seen, no beats, remainder ignored.
    set_pl(46, 0, 1);
    build_frame(STATION, SRC_B, 16'h0800, 1'b1);
    hdr_q.push_back({SRC_B, 16'h0800});
    frame_dibs(0);
    send_dibs(100);
    drain("mid_reset");

    // Good frame after the reset.
    set_pl(46, 0, 1);
    build_frame(BCAST, STATION, 16'h0800, 1'b1);
    expect_frame(STATION, 16'h0800, 46, 1'b0);
    frame_dibs(0);
    send_dibs(-1);
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
